// File: rtl/sev_seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: shadow/active digit banks with
// frame-aligned commit, 16-level PWM brightness, per-digit blank and blink.
module sev_seg_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 100000,
    parameter int BLINK_DIV  = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [4:0] wr_data,
    input  logic       commit,
    input  logic [3:0] brightness,
    input  logic [7:0] blank_mask,
    input  logic [7:0] blink_mask,
    output logic [6:0] Seg,
    output logic       DP,
    output logic [7:0] AN,
    output logic       frame_done
);

    localparam int P_W  = $clog2(SCAN_DIV);
    localparam int SUB  = SCAN_DIV / 16;
    localparam int Q_W  = $clog2(SUB);
    localparam int FC_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [P_W-1:0]  P_LAST  = P_W'(SCAN_DIV - 1);
    localparam logic [Q_W-1:0]  Q_LAST  = Q_W'(SUB - 1);
    localparam logic [2:0]      S_LAST  = 3'(NUM_DIGITS - 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_DIV - 1);
    localparam logic [3:0]      N_DIG   = 4'(NUM_DIGITS);

    // Active-low hex decode, bit order g..a.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        case (v)
            4'h0: hex_to_seg = 7'b1000000;
            4'h1: hex_to_seg = 7'b1111001;
            4'h2: hex_to_seg = 7'b0100100;
            4'h3: hex_to_seg = 7'b0110000;
            4'h4: hex_to_seg = 7'b0011001;
            4'h5: hex_to_seg = 7'b0010010;
            4'h6: hex_to_seg = 7'b0000010;
            4'h7: hex_to_seg = 7'b1111000;
            4'h8: hex_to_seg = 7'b0000000;
            4'h9: hex_to_seg = 7'b0010000;
            4'hA: hex_to_seg = 7'b0001000;
            4'hB: hex_to_seg = 7'b0000011;
            4'hC: hex_to_seg = 7'b1000110;
            4'hD: hex_to_seg = 7'b0100001;
            4'hE: hex_to_seg = 7'b0000110;
            default: hex_to_seg = 7'b0001110;
        endcase
    endfunction

    logic [P_W-1:0]  p;
    logic [Q_W-1:0]  q;
    logic [3:0]      phase;
    logic [2:0]      s;
    logic [FC_W-1:0] frame_cnt;
    logic            blink_phase;
    logic            pending;
    logic [4:0]      shadow [8];
    logic [4:0]      active [8];

    logic            p_wrap;
    logic            frame_end;
    logic [4:0]      cur_p0;
    logic            lit_p0;
    logic [7:0]      an_p0;

    // Stage p0: decode current scan state into next output values.
    // phase tracks p / (SCAN_DIV/16) with a sub-counter instead of a divider.
    always_comb begin
        p_wrap    = (p == P_LAST);
        frame_end = p_wrap && (s == S_LAST);
        cur_p0    = active[s];
        lit_p0    = (p != '0) && (phase <= brightness) && !blank_mask[s]
                    && !(blink_mask[s] && blink_phase);
        an_p0     = 8'hFF;
        if (lit_p0) an_p0[s] = 1'b0;
    end

    // Stage p1: registered counters, digit banks and outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            p           <= '0;
            q           <= '0;
            phase       <= '0;
            s           <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            pending     <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
            Seg        <= 7'h7F;
            DP         <= 1'b1;
            AN         <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            if (p_wrap) begin
                p     <= '0;
                q     <= '0;
                phase <= '0;
                s     <= (s == S_LAST) ? 3'd0 : s + 3'd1;
            end else begin
                p <= p + 1'b1;
                if (q == Q_LAST) begin
                    q     <= '0;
                    phase <= phase + 4'd1;
                end else begin
                    q <= q + 1'b1;
                end
            end

            if (frame_end) begin
                if (frame_cnt == FC_LAST) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end

            if (wr_en && ({1'b0, wr_addr} < N_DIG)) shadow[wr_addr] <= wr_data;

            // Non-blocking copy picks up the pre-write shadow contents.
            if (frame_end && (pending || commit)) begin
                for (int i = 0; i < 8; i++) active[i] <= shadow[i];
                pending <= 1'b0;
            end else if (commit) begin
                pending <= 1'b1;
            end

            Seg        <= hex_to_seg(cur_p0[3:0]);
            DP         <= ~cur_p0[4];
            AN         <= an_p0;
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_sev_seg_scan_ctrl.sv
// Bench for sev_seg_scan_ctrl: directed scenarios plus random traffic checked
// cycle by cycle against an arithmetic model of the scan timeline.
module tb_sev_seg_scan_ctrl;

    localparam int ND  = 4;
    localparam int SD  = 32;
    localparam int BD  = 2;
    localparam int FRM = ND * SD;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [4:0] wr_data;
    logic       commit;
    logic [3:0] brightness;
    logic [7:0] blank_mask;
    logic [7:0] blink_mask;
    logic [6:0] Seg;
    logic       DP;
    logic [7:0] AN;
    logic       frame_done;

    sev_seg_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .commit(commit), .brightness(brightness),
        .blank_mask(blank_mask), .blink_mask(blink_mask),
        .Seg(Seg), .DP(DP), .AN(AN), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Segments that glow for each hex value, active-high, bit order g..a.
    localparam logic [6:0] SEG_ON [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    int n_checks = 0;
    int n_errors = 0;

    logic [4:0] m_shadow [8];
    logic [4:0] m_active [8];
    logic       m_pending;
    int         m_t;
    int         since_rst;
    bit         first_fd;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0d got %0h want %0h", tag, m_t, obs, exp);
        end
    endtask

    // One clock: predict registered outputs from the model state and the
    // present inputs, advance the model, then compare after the edge.
    task automatic step();
        logic [7:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp, e_fd, lit, fe;
        logic [4:0] cur;
        int pp, ss, bp;
        if (reset) begin
            e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
            for (int i = 0; i < 8; i++) begin
                m_shadow[i] = '0;
                m_active[i] = '0;
            end
            m_pending = 1'b0;
            m_t = 0;
            since_rst = 0;
            first_fd = 1'b1;
        end else begin
            pp  = m_t % SD;
            ss  = (m_t / SD) % ND;
            bp  = (m_t / FRM / BD) % 2;
            fe  = (m_t % FRM) == FRM - 1;
            cur = m_active[ss];
            lit = (pp != 0) && ((pp / (SD / 16)) <= int'(brightness))
                  && !blank_mask[ss] && !(blink_mask[ss] && bp == 1);
            e_an  = lit ? ~(8'b1 << ss) : 8'hFF;
            e_seg = ~SEG_ON[cur[3:0]];
            e_dp  = ~cur[4];
            e_fd  = fe;
            if (fe && (m_pending || commit)) begin
                for (int i = 0; i < 8; i++) m_active[i] = m_shadow[i];
                m_pending = 1'b0;
            end else if (commit) begin
                m_pending = 1'b1;
            end
            if (wr_en && int'(wr_addr) < ND) m_shadow[wr_addr] = wr_data;
            m_t++;
            since_rst++;
        end
        @(posedge clk);
        #1;
        check_eq("AN", 32'(AN), 32'(e_an));
        check_eq("Seg", 32'(Seg), 32'(e_seg));
        check_eq("DP", 32'(DP), 32'(e_dp));
        check_eq("frame_done", 32'(frame_done), 32'(e_fd));
        if (!reset && first_fd && frame_done) begin
            check_eq("first_fd_latency", 32'(since_rst), 32'(FRM));
            first_fd = 1'b0;
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic write_digit(input logic [2:0] a, input logic [4:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic advance_to(input int tmod);
        for (int k = 0; k < 2 * FRM && (m_t % FRM) != tmod; k++) step();
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; commit = 1'b0;
        brightness = 4'd15; blank_mask = '0; blink_mask = '0;
        m_t = 0; since_rst = 0; first_fd = 1'b1; m_pending = 1'b0;
        run(3);
        reset = 1'b0;

        // Load 1,2,3.,4 and commit at full brightness.
        write_digit(3'd0, 5'h01);
        write_digit(3'd1, 5'h02);
        write_digit(3'd2, 5'h13);
        write_digit(3'd3, 5'h04);
        commit = 1'b1; step(); commit = 1'b0;
        run(3 * FRM);

        // Writes without commit, then commit exactly in the frame-end cycle
        // while also writing digit 0.
        write_digit(3'd0, 5'h0A);
        write_digit(3'd1, 5'h1B);
        write_digit(3'd3, 5'h0F);
        run(FRM);
        advance_to(FRM - 1);
        commit = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 5'h08;
        step();
        commit = 1'b0; wr_en = 1'b0;
        run(FRM + 5);

        // Dimming.
        brightness = 4'd3;  run(FRM);
        brightness = 4'd0;  run(FRM);
        brightness = 4'd15;

        // Blink and blank over eight frames counted from reset.
        reset = 1'b1; run(2); reset = 1'b0;
        for (int i = 0; i < ND; i++) write_digit(3'(i), 5'(8 + i));
        commit = 1'b1; step(); commit = 1'b0;
        blink_mask = 8'b0000_0010; blank_mask = 8'b0000_1000;
        run(8 * FRM);
        blink_mask = '0; blank_mask = '0;

        // Out-of-range addresses are ignored.
        for (int k = 0; k < 8; k++) write_digit(3'(4 + (k % 4)), 5'($urandom));
        commit = 1'b1; step(); commit = 1'b0;
        run(2 * FRM);

        // Reset mid slot 2 with a commit pending and a write in flight.
        write_digit(3'd2, 5'h17);
        advance_to(70);
        commit = 1'b1; step(); commit = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 5'h19; step(); wr_en = 1'b0;
        reset = 1'b1; wr_en = 1'b1; run(2); reset = 1'b0; wr_en = 1'b0;
        run(2 * FRM + 3);

        // Random traffic.
        for (int k = 0; k < 4000; k++) begin
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 3'($urandom);
            wr_data = 5'($urandom);
            commit  = ($urandom_range(0, 60) == 0);
            if ($urandom_range(0, 150) == 0) brightness = 4'($urandom);
            if ($urandom_range(0, 300) == 0) blank_mask = 8'($urandom);
            if ($urandom_range(0, 300) == 0) blink_mask = 8'($urandom);
            reset   = ($urandom_range(0, 1499) == 0);
            step();
        end
        reset = 1'b0; wr_en = 1'b0; commit = 1'b0;
        run(4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
